// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sharing of one radix-4 Booth 16x16 multiplier between two MAC requesters
//   clk, reset_n          : rising-edge clock, asynchronous active-low reset
//   req/op/x/y/gnt{0,1}   : requester handshake; operands captured on the edge where gnt is high
//   rsp_vld/id/data/ovf   : one-cycle response strobe; id/data hold their last value between responses
//   busy                  : high while an operation is in EXEC or RESP
module booth_mul_arbiter #(
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [15:0]      x0,
    input  logic [15:0]      y0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [15:0]      x1,
    input  logic [15:0]      y1,
    output logic             gnt1,
    output logic             rsp_vld,
    output logic             rsp_id,
    output logic [ACC_W-1:0] rsp_data,
    output logic             rsp_ovf,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nx;
    logic last, id_r, id_q, mac, ovf_nx;
    logic [1:0] op_r;
    logic signed [15:0] x_r, y_r;
    logic signed [31:0] prod, prod_c, xs;
    logic [16:0] ye;
    logic [2:0] g;
    logic signed [ACC_W-1:0] acc0, acc1, acc_sel, pe, sum, acc_nx, data_nx, data_q;

    // Booth core: each 3-bit window of {y,0} selects a digit in -2..2 weighted by 4^i
    always_comb begin
        prod_c = '0;
        xs = 32'(x_r);
        ye = {y_r, 1'b0};
        g = '0;
        for (int i = 0; i < 8; i++) begin
            g = 3'(ye >> (2 * i));
            prod_c = prod_c + ((g == 3'b011 ? xs <<< 1 : g == 3'b100 ? -(xs <<< 1) :
                                g == 3'b001 || g == 3'b010 ? xs :
                                g == 3'b101 || g == 3'b110 ? -xs : 32'sd0) <<< (2 * i));
        end
    end

    // when both request, the one that did not win last time gets the grant
    always_comb begin
        gnt0 = state != EXEC && req0 && (!req1 || last);
        gnt1 = state != EXEC && req1 && (!req0 || !last);
        state_nx = gnt0 || gnt1 ? EXEC : state == EXEC ? RESP : IDLE;
        rsp_vld = state == RESP;
        busy = state != IDLE;
    end

    // the registered product is accumulated during RESP, keeping multiply and add in separate cycles
    always_comb begin
        pe = ACC_W'(prod);
        acc_sel = id_r ? acc1 : acc0;
        sum = acc_sel + pe;
        mac = op_r == 2'b01;
        acc_nx = mac ? sum : op_r == 2'b10 ? pe : acc_sel;
        data_nx = mac || op_r == 2'b10 ? acc_nx : pe;
        ovf_nx = mac && acc_sel[ACC_W-1] == pe[ACC_W-1] && sum[ACC_W-1] != acc_sel[ACC_W-1];
        rsp_id = rsp_vld ? id_r : id_q;
        rsp_data = rsp_vld ? data_nx : data_q;
        rsp_ovf = rsp_vld && ovf_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            last <= 1'b1;
            id_r <= 1'b0;
            id_q <= 1'b0;
            op_r <= '0;
            x_r <= '0;
            y_r <= '0;
            prod <= '0;
            acc0 <= '0;
            acc1 <= '0;
            data_q <= '0;
        end else begin
            state <= state_nx;
            if (gnt0 || gnt1) begin
                last <= gnt1;
                id_r <= gnt1;
                op_r <= gnt1 ? op1 : op0;
                x_r <= gnt1 ? x1 : x0;
                y_r <= gnt1 ? y1 : y0;
            end
            if (state == EXEC)
                prod <= prod_c;
            if (state == RESP) begin
                id_q <= id_r;
                data_q <= data_nx;
                if (id_r)
                    acc1 <= acc_nx;
                else
                    acc0 <= acc_nx;
            end
        end
    end
endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
Sequencer and arbiter that shares one instance of the team's combinational 16x16 signed radix-4 Booth multiplier core (z = x*y, 32-bit) between two requesters. Each requester has a private accumulator, so it can issue plain multiply or multiply-accumulate operations. The block registers operands and the product to break the long combinational path. It grants round-robin and returns the result with the requester ID on a shared response bus.

Parameters:
ACC_W, 40, accumulator and response data width in bits; legal range 32..64. Operand width is fixed at 16 to match the core.

Ports:
clk  input  1  clock; all registers on rising edge
reset_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 request; held high until gnt0
op0  input  2  requester 0 opcode: 00 MUL, 01 MAC, 10 MAC-clear, 11 treated as MUL
x0  input  16  requester 0 signed multiplicand
y0  input  16  requester 0 signed multiplier
gnt0  output  1  one-cycle grant; operands captured on this edge
req1, op1, x1, y1, gnt1  as above for requester 1
rsp_vld  output  1  one-cycle response strobe
rsp_id  output  1  requester that owns the response
rsp_data  output  ACC_W  signed result
rsp_ovf  output  1  signed overflow on this accumulate
busy  output  1  high in EXEC and RESP states

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all operand, product, accumulator and response registers cleared to 0; gnt0=gnt1=rsp_vld=rsp_ovf=busy=0; rr pointer last=1, so requester 0 wins first.
- FSM states: IDLE, EXEC, RESP.
- Grant rules:
  - gnt is combinational and asserted only in IDLE or RESP when a req is high.
  - Only one requester is granted. If both request, the one not equal to last is granted; last updates on every grant.
  - Never grant in EXEC.
- Grant edge: latch x, y, op and id into operand regs; go to EXEC.
- IDLE: with no req, stay in IDLE.
- EXEC:
  - The product register captures core(x_r, y_r), 32-bit signed.
  - Accumulator update for acc[id]:
    - MAC (01): acc[id] <= acc[id] + sext(product).
    - MAC-clear (10): acc[id] <= sext(product).
    - MUL and 11: acc[id] unchanged.
  - Arithmetic is modulo 2^ACC_W.
  - Go to RESP.
- RESP (one cycle):
  - rsp_vld=1 and rsp_id=id.
  - rsp_data = sext(product) for MUL/11; the new acc[id] for MAC and MAC-clear.
  - rsp_ovf=1 only for MAC when both addends share a sign and the sum sign differs; else 0.
  - If a req is present, grant it in this same cycle and go to EXEC; otherwise go to IDLE.
- rsp_data and rsp_id hold their last value outside RESP; rsp_vld is only valid in RESP.
- Timing:
  - Latency: grant at edge T, rsp_vld high in cycle T+2.
  - Sustained throughput: one op per 2 cycles.
  - No stalls; the response cannot be back-pressured.
- Other requester's accumulator is never modified.
- Requester drops req without a grant: legal; the request is simply not seen.
- Reset mid-operation: the in-flight op is discarded with no rsp_vld, and accumulators are cleared.
- Inputs are sampled only on grant edges; operand changes at other times have no effect.

Test Plan:
1. Reset; req0 op=00 x=3 y=-5 -> gnt0 in cycle 0; rsp_vld in cycle 2 with rsp_id=0, rsp_data=0xFFFFFFFFF1 (-15, ACC_W=40), rsp_ovf=0; back to IDLE with busy=0.
2. req0 and req1 both held high, op=00, for 4 ops -> grants in order 0,1,0,1. Each new grant coincides with the previous rsp_vld. rsp_vld occurs every 2 cycles and rsp_id alternates 0,1,0,1.
3. Requester 1, op=10 with x=100 y=200 -> 20000. Then op=01 with x=-32768 y=-32768 -> 1073761824. Then requester 0, op=01 with x=1 y=1 -> 1, proving acc0 is isolated.
4. ACC_W=32: req0 op=10 with -32768*-32768 -> 0x40000000, rsp_ovf=0. Then op=01 with the same operands -> rsp_data=0x80000000, rsp_ovf=1 (wrap).
5. Pull reset_n low during EXEC -> no rsp_vld, busy=0 immediately, acc cleared. After release, a simultaneous req0/req1 grants 0 first.
6. op=11 with x=32767 y=-32768 -> rsp_data=-1073709056 sign-extended, accumulator unchanged (checked by a following op=01 with 0*0 returning the prior value).
